mod_n_updown_counter: RTL and testbench

Parametrised up/down counter with modulus N and wrap or saturate mode. Adds synchronous clear, range-checked parallel load and terminal-count flags. Successor to the fixed-modulus time-field counters in the clock datapath; one instance serves each hours, minutes, seconds or date field. Fields are chained through o_carryup/o_borrowdown into the next field's i_up/i_down.

---
 rtl/mod_n_updown_counter_if.sv | 27 ++
 rtl/mod_n_updown_counter.sv | 87 ++++++++
 tb/tb_mod_n_updown_counter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_n_updown_counter_if.sv
// rtl/mod_n_updown_counter_if.sv - control and status bundle for one counter field
interface mod_n_updown_counter_if #(
    parameter int WIDTH = 5
);
    logic             i_clear;
    logic             i_load;
    logic [WIDTH-1:0] i_load_value;
    logic             i_up;
    logic             i_down;
    logic [WIDTH-1:0] o_count;
    logic             o_carryup;
    logic             o_borrowdown;
    logic             o_at_max;
    logic             o_at_min;
    logic             o_load_err;
    logic             o_wrapped;

    modport master (
        output i_clear, i_load, i_load_value, i_up, i_down,
        input  o_count, o_carryup, o_borrowdown, o_at_max, o_at_min, o_load_err, o_wrapped
    );

    modport slave (
        input  i_clear, i_load, i_load_value, i_up, i_down,
        output o_count, o_carryup, o_borrowdown, o_at_max, o_at_min, o_load_err, o_wrapped
    );
endinterface

// File: rtl/mod_n_updown_counter.sv
// rtl/mod_n_updown_counter.sv - modulus-N up/down counter with wrap or saturate ends
module mod_n_updown_counter #(
    parameter int MODULUS     = 24,
    parameter int WIDTH       = 5,
    parameter int WRAP_MODE   = 1,
    parameter int RESET_VALUE = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mod_n_updown_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL   = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH:0]   MAX_EXT   = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH:0]   LIMIT_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic             WRAP      = (WRAP_MODE != 0);

    logic [WIDTH-1:0] count_q, count_d;
    logic             load_err_q, load_err_d;
    logic             wrapped_q, wrapped_d;
    logic             up_req, down_req;
    logic             at_max, at_min;
    logic [WIDTH:0]   inc_ext;

    assign up_req   = bus.i_up & ~bus.i_down;
    assign down_req = bus.i_down & ~bus.i_up;
    assign at_max   = (count_q == MAX_VAL);
    assign at_min   = (count_q == '0);
    // Extra bit keeps MODULUS == 2^WIDTH from silently overflowing to zero
    assign inc_ext  = {1'b0, count_q} + (WIDTH + 1)'(1);

    always_comb begin
        count_d    = count_q;
        load_err_d = 1'b0;
        wrapped_d  = wrapped_q;
        if (bus.i_clear) begin
            count_d   = RST_VAL;
            wrapped_d = 1'b0;
        end else if (bus.i_load) begin
            if ({1'b0, bus.i_load_value} < LIMIT_EXT) begin
                count_d = bus.i_load_value;
            end else begin
                count_d    = MAX_VAL;
                load_err_d = 1'b1;
            end
        end else if (up_req) begin
            if (inc_ext > MAX_EXT) begin
                if (WRAP) begin
                    count_d   = '0;
                    wrapped_d = 1'b1;
                end
            end else begin
                count_d = inc_ext[WIDTH-1:0];
            end
        end else if (down_req) begin
            if (at_min) begin
                if (WRAP) begin
                    count_d   = MAX_VAL;
                    wrapped_d = 1'b1;
                end
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q    <= RST_VAL;
            load_err_q <= 1'b0;
            wrapped_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= load_err_d;
            wrapped_q  <= wrapped_d;
        end
    end

    // Same-cycle carry/borrow lets the next field step on this very edge
    assign bus.o_carryup    = WRAP & up_req & ~bus.i_load & ~bus.i_clear & ~i_rst & at_max;
    assign bus.o_borrowdown = WRAP & down_req & ~bus.i_load & ~bus.i_clear & ~i_rst & at_min;
    assign bus.o_count      = count_q;
    assign bus.o_at_max     = at_max;
    assign bus.o_at_min     = at_min;
    assign bus.o_load_err   = load_err_q;
    assign bus.o_wrapped    = wrapped_q;
endmodule

// File: tb/tb_mod_n_updown_counter.sv
// tb/tb_mod_n_updown_counter.sv - directed bench across wrap, saturate, reset-value and power-of-two builds
module tb_mod_n_updown_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mod_n_updown_counter_if #(.WIDTH(5)) if24 ();
    mod_n_updown_counter_if #(.WIDTH(6)) if60 ();
    mod_n_updown_counter_if #(.WIDTH(5)) ifrv ();
    mod_n_updown_counter_if #(.WIDTH(5)) if32 ();

    mod_n_updown_counter #(.MODULUS(24), .WIDTH(5), .WRAP_MODE(1), .RESET_VALUE(0))
        u24 (.i_clk(clk), .i_rst(rst), .bus(if24));
    mod_n_updown_counter #(.MODULUS(60), .WIDTH(6), .WRAP_MODE(0), .RESET_VALUE(0))
        u60 (.i_clk(clk), .i_rst(rst), .bus(if60));
    mod_n_updown_counter #(.MODULUS(24), .WIDTH(5), .WRAP_MODE(1), .RESET_VALUE(1))
        urv (.i_clk(clk), .i_rst(rst), .bus(ifrv));
    mod_n_updown_counter #(.MODULUS(32), .WIDTH(5), .WRAP_MODE(1), .RESET_VALUE(0))
        u32 (.i_clk(clk), .i_rst(rst), .bus(if32));

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic idle_all;
        if24.i_clear = 0; if24.i_load = 0; if24.i_load_value = '0; if24.i_up = 0; if24.i_down = 0;
        if60.i_clear = 0; if60.i_load = 0; if60.i_load_value = '0; if60.i_up = 0; if60.i_down = 0;
        ifrv.i_clear = 0; ifrv.i_load = 0; ifrv.i_load_value = '0; ifrv.i_up = 0; ifrv.i_down = 0;
        if32.i_clear = 0; if32.i_load = 0; if32.i_load_value = '0; if32.i_up = 0; if32.i_down = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_all();
        if24.i_up = 1'b1;
        repeat (3) tick();
        checks++;
        if (if24.o_count !== 5'd0) begin
            errors++; $display("FAIL reset_count24: got %0d expected 0", if24.o_count);
        end
        checks++;
        if (ifrv.o_count !== 5'd1) begin
            errors++; $display("FAIL reset_count_rv1: got %0d expected 1", ifrv.o_count);
        end
        checks++;
        if (if24.o_at_min !== 1'b1 || if24.o_at_max !== 1'b0) begin
            errors++; $display("FAIL reset_flags24: got min=%0b max=%0b expected min=1 max=0", if24.o_at_min, if24.o_at_max);
        end
        checks++;
        if (ifrv.o_at_min !== 1'b0) begin
            errors++; $display("FAIL reset_at_min_rv1: got %0b expected 0", ifrv.o_at_min);
        end
        checks++;
        if (if24.o_load_err !== 1'b0 || if24.o_wrapped !== 1'b0 || if24.o_carryup !== 1'b0) begin
            errors++; $display("FAIL reset_status24: got err=%0b wrapped=%0b carry=%0b expected 0 0 0",
                                if24.o_load_err, if24.o_wrapped, if24.o_carryup);
        end
        checks++;
        if (if60.o_count !== 6'd0 || if32.o_count !== 5'd0) begin
            errors++; $display("FAIL reset_count_others: got n60=%0d n32=%0d expected 0 0", if60.o_count, if32.o_count);
        end
        if24.i_up = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_wrap_up;
        for (int i = 0; i < 24; i++) begin
            if24.i_up = 1'b1;
            #1;
            checks++;
            if (if24.o_count !== 5'(i)) begin
                errors++; $display("FAIL wrap_up_count[%0d]: got %0d expected %0d", i, if24.o_count, i);
            end
            checks++;
            if (if24.o_carryup !== (i == 23)) begin
                errors++; $display("FAIL wrap_up_carry[%0d]: got %0b expected %0b", i, if24.o_carryup, (i == 23));
            end
            checks++;
            if (if24.o_at_max !== (i == 23)) begin
                errors++; $display("FAIL wrap_up_at_max[%0d]: got %0b expected %0b", i, if24.o_at_max, (i == 23));
            end
            tick();
        end
        if24.i_up = 1'b0;
        #1;
        checks++;
        if (if24.o_count !== 5'd0 || if24.o_wrapped !== 1'b1) begin
            errors++; $display("FAIL wrap_up_end: got count=%0d wrapped=%0b expected 0 1", if24.o_count, if24.o_wrapped);
        end
    endtask

    task automatic test_wrap_down;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (if24.o_count !== 5'd0 || if24.o_wrapped !== 1'b0) begin
            errors++; $display("FAIL wrap_down_start: got count=%0d wrapped=%0b expected 0 0", if24.o_count, if24.o_wrapped);
        end
        if24.i_down = 1'b1;
        #1;
        checks++;
        if (if24.o_borrowdown !== 1'b1 || if24.o_carryup !== 1'b0) begin
            errors++; $display("FAIL wrap_down_borrow: got borrow=%0b carry=%0b expected 1 0", if24.o_borrowdown, if24.o_carryup);
        end
        tick();
        if24.i_down = 1'b0;
        #1;
        checks++;
        if (if24.o_count !== 5'd23 || if24.o_wrapped !== 1'b1 || if24.o_at_max !== 1'b1) begin
            errors++; $display("FAIL wrap_down_end: got count=%0d wrapped=%0b max=%0b expected 23 1 1",
                                if24.o_count, if24.o_wrapped, if24.o_at_max);
        end
        checks++;
        if (if24.o_borrowdown !== 1'b0) begin
            errors++; $display("FAIL wrap_down_borrow_idle: got %0b expected 0", if24.o_borrowdown);
        end
    endtask

    task automatic test_saturate;
        if60.i_load = 1'b1;
        if60.i_load_value = 6'd59;
        tick();
        if60.i_load = 1'b0;
        checks++;
        if (if60.o_count !== 6'd59 || if60.o_load_err !== 1'b0) begin
            errors++; $display("FAIL sat_load59: got count=%0d err=%0b expected 59 0", if60.o_count, if60.o_load_err);
        end
        for (int i = 0; i < 3; i++) begin
            if60.i_up = 1'b1;
            #1;
            checks++;
            if (if60.o_carryup !== 1'b0) begin
                errors++; $display("FAIL sat_carry[%0d]: got %0b expected 0", i, if60.o_carryup);
            end
            tick();
            checks++;
            if (if60.o_count !== 6'd59) begin
                errors++; $display("FAIL sat_hold_max[%0d]: got %0d expected 59", i, if60.o_count);
            end
        end
        if60.i_up = 1'b0;
        if60.i_load = 1'b1;
        if60.i_load_value = 6'd0;
        tick();
        if60.i_load = 1'b0;
        if60.i_down = 1'b1;
        #1;
        checks++;
        if (if60.o_borrowdown !== 1'b0) begin
            errors++; $display("FAIL sat_borrow: got %0b expected 0", if60.o_borrowdown);
        end
        tick();
        if60.i_down = 1'b0;
        checks++;
        if (if60.o_count !== 6'd0 || if60.o_wrapped !== 1'b0) begin
            errors++; $display("FAIL sat_hold_min: got count=%0d wrapped=%0b expected 0 0", if60.o_count, if60.o_wrapped);
        end
    endtask

    task automatic test_load;
        if24.i_load = 1'b1;
        if24.i_load_value = 5'd17;
        tick();
        if24.i_load = 1'b0;
        checks++;
        if (if24.o_count !== 5'd17 || if24.o_load_err !== 1'b0) begin
            errors++; $display("FAIL load17: got count=%0d err=%0b expected 17 0", if24.o_count, if24.o_load_err);
        end
        if24.i_load = 1'b1;
        if24.i_load_value = 5'd30;
        tick();
        if24.i_load = 1'b0;
        checks++;
        if (if24.o_count !== 5'd23 || if24.o_load_err !== 1'b1) begin
            errors++; $display("FAIL load30: got count=%0d err=%0b expected 23 1", if24.o_count, if24.o_load_err);
        end
        // Load together with up at the top of range: load wins, no carry
        if24.i_load = 1'b1;
        if24.i_load_value = 5'd5;
        if24.i_up = 1'b1;
        #1;
        checks++;
        if (if24.o_carryup !== 1'b0) begin
            errors++; $display("FAIL load_up_carry: got %0b expected 0", if24.o_carryup);
        end
        tick();
        if24.i_load = 1'b0;
        if24.i_up = 1'b0;
        checks++;
        if (if24.o_count !== 5'd5 || if24.o_load_err !== 1'b0) begin
            errors++; $display("FAIL load_up_count: got count=%0d err=%0b expected 5 0", if24.o_count, if24.o_load_err);
        end
    endtask

    task automatic test_priority;
        ifrv.i_load = 1'b1;
        ifrv.i_load_value = 5'd10;
        tick();
        ifrv.i_load = 1'b0;
        ifrv.i_up = 1'b1;
        ifrv.i_down = 1'b1;
        #1;
        checks++;
        if (ifrv.o_carryup !== 1'b0 || ifrv.o_borrowdown !== 1'b0) begin
            errors++; $display("FAIL updown_flags: got carry=%0b borrow=%0b expected 0 0", ifrv.o_carryup, ifrv.o_borrowdown);
        end
        tick();
        ifrv.i_up = 1'b0;
        ifrv.i_down = 1'b0;
        checks++;
        if (ifrv.o_count !== 5'd10) begin
            errors++; $display("FAIL updown_count: got %0d expected 10", ifrv.o_count);
        end
        ifrv.i_load = 1'b1;
        ifrv.i_load_value = 5'd23;
        tick();
        ifrv.i_load = 1'b0;
        ifrv.i_up = 1'b1;
        tick();
        ifrv.i_up = 1'b0;
        checks++;
        if (ifrv.o_count !== 5'd0 || ifrv.o_wrapped !== 1'b1) begin
            errors++; $display("FAIL rv_wrap: got count=%0d wrapped=%0b expected 0 1", ifrv.o_count, ifrv.o_wrapped);
        end
        ifrv.i_clear = 1'b1;
        ifrv.i_load = 1'b1;
        ifrv.i_load_value = 5'd7;
        tick();
        ifrv.i_clear = 1'b0;
        ifrv.i_load = 1'b0;
        checks++;
        if (ifrv.o_count !== 5'd1 || ifrv.o_wrapped !== 1'b0) begin
            errors++; $display("FAIL clear_load: got count=%0d wrapped=%0b expected 1 0", ifrv.o_count, ifrv.o_wrapped);
        end
        ifrv.i_load = 1'b1;
        ifrv.i_load_value = 5'd23;
        tick();
        ifrv.i_load = 1'b0;
        rst = 1'b1;
        ifrv.i_up = 1'b1;
        #1;
        checks++;
        if (ifrv.o_carryup !== 1'b0) begin
            errors++; $display("FAIL rst_carry: got %0b expected 0", ifrv.o_carryup);
        end
        tick();
        rst = 1'b0;
        ifrv.i_up = 1'b0;
        checks++;
        if (ifrv.o_count !== 5'd1) begin
            errors++; $display("FAIL rst_up_count: got %0d expected 1", ifrv.o_count);
        end
        ifrv.i_load = 1'b1;
        ifrv.i_load_value = 5'd20;
        tick();
        rst = 1'b1;
        ifrv.i_clear = 1'b1;
        ifrv.i_load_value = 5'd30;
        tick();
        rst = 1'b0;
        ifrv.i_clear = 1'b0;
        ifrv.i_load = 1'b0;
        checks++;
        if (ifrv.o_count !== 5'd1 || ifrv.o_load_err !== 1'b0) begin
            errors++; $display("FAIL rst_clear_load: got count=%0d err=%0b expected 1 0", ifrv.o_count, ifrv.o_load_err);
        end
        ifrv.i_up = 1'b1;
        tick();
        ifrv.i_up = 1'b0;
        checks++;
        if (ifrv.o_count !== 5'd2) begin
            errors++; $display("FAIL post_rst_up: got %0d expected 2", ifrv.o_count);
        end
    endtask

    task automatic test_pow2;
        if32.i_load = 1'b1;
        if32.i_load_value = 5'd31;
        tick();
        if32.i_load = 1'b0;
        checks++;
        if (if32.o_count !== 5'd31 || if32.o_at_max !== 1'b1 || if32.o_load_err !== 1'b0) begin
            errors++; $display("FAIL pow2_load31: got count=%0d max=%0b err=%0b expected 31 1 0",
                                if32.o_count, if32.o_at_max, if32.o_load_err);
        end
        if32.i_up = 1'b1;
        #1;
        checks++;
        if (if32.o_carryup !== 1'b1) begin
            errors++; $display("FAIL pow2_carry: got %0b expected 1", if32.o_carryup);
        end
        tick();
        if32.i_up = 1'b0;
        checks++;
        if (if32.o_count !== 5'd0 || if32.o_wrapped !== 1'b1) begin
            errors++; $display("FAIL pow2_wrap: got count=%0d wrapped=%0b expected 0 1", if32.o_count, if32.o_wrapped);
        end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load();
        test_priority();
        test_pow2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
